// File: rtl/heap_cmd_pkg.sv
// Shared command encodings, sizing constants and sequencer state encoding
// for the heap sort sequencer and its gap timer.
package heap_cmd_pkg;

    localparam int unsigned HEAP_SIZE_DEF = 25;
    localparam int unsigned CNT_W         = 5;
    localparam int unsigned RD_W          = 5;

    localparam logic [RD_W-1:0] RD_PUSH = 5'd0;
    localparam logic [RD_W-1:0] RD_POP  = 5'd1;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        PUSH,
        PUSH_WAIT,
        POP,
        CAPTURE,
        POP_WAIT,
        EMIT,
        DONE
    } state_t;

endpackage

// File: rtl/heap_gap_timer.sv
// Loadable saturating down-counter; zero flags that the heap unit has had
// enough idle cycles since the last command.
module heap_gap_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/heap_sort_sequencer.sv
// Feeds a job of words into an external max-heap unit, then pops them back
// out as a descending stream, spacing commands so the heap can settle.
module heap_sort_sequencer
    import heap_cmd_pkg::*;
#(
    parameter int unsigned DW        = 32,
    parameter int unsigned HEAP_SIZE = HEAP_SIZE_DEF,
    parameter int unsigned GAP       = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DW-1:0]    s_data,
    output logic             cmd_v,
    output logic [RD_W-1:0]  cmd_rd,
    output logic [DW-1:0]    cmd_data,
    input  logic [DW-1:0]    rsp_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DW-1:0]    m_data,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned GW = $clog2(GAP + 2);

    state_t           state, state_nx;
    logic [CNT_W-1:0] remaining, pops;
    logic [DW-1:0]    word, m_data_q;
    logic [RD_W-1:0]  rd_q;
    logic             err_q, start_ok;
    logic             gap_load, gap_dec, gap_zero;

    assign start_ok = start && (count != '0) && (32'(count) <= HEAP_SIZE);

    heap_gap_timer #(.W(GW)) u_gap (
        .clk   (clk),
        .reset (reset),
        .load  (gap_load),
        .value (GW'(GAP)),
        .dec   (gap_dec),
        .zero  (gap_zero)
    );

    always_comb begin
        state_nx = state;
        gap_load = 1'b0;
        gap_dec  = 1'b0;
        case (state)
            IDLE:      if (start_ok) state_nx = LOAD;
            LOAD:      if (s_valid) state_nx = PUSH;
            PUSH: begin
                gap_load = 1'b1;
                state_nx = PUSH_WAIT;
            end
            PUSH_WAIT: begin
                gap_dec = 1'b1;
                if (gap_zero) state_nx = (remaining != '0) ? LOAD : POP;
            end
            POP:       state_nx = CAPTURE;
            CAPTURE: begin
                gap_load = 1'b1;
                state_nx = EMIT;
            end
            // Gap keeps running while the sink stalls, so a slow consumer
            // does not add extra idle time before the next pop.
            EMIT: begin
                gap_dec = 1'b1;
                if (m_ready) state_nx = POP_WAIT;
            end
            POP_WAIT: begin
                gap_dec = 1'b1;
                if (gap_zero) state_nx = (pops != '0) ? POP : DONE;
            end
            DONE:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            remaining <= '0;
            pops      <= '0;
            word      <= '0;
            m_data_q  <= '0;
            rd_q      <= RD_PUSH;
            err_q     <= 1'b0;
        end else begin
            state <= state_nx;
            rd_q  <= cmd_rd;
            err_q <= (state == IDLE) && start && !start_ok;
            case (state)
                IDLE: if (start_ok) begin
                    remaining <= count;
                    pops      <= count;
                end
                LOAD:    if (s_valid) word <= s_data;
                PUSH:    remaining <= remaining - CNT_W'(1);
                CAPTURE: m_data_q <= rsp_data;
                EMIT:    if (m_ready) pops <= pops - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign s_ready  = (state == LOAD);
    assign cmd_v    = (state == PUSH) || (state == POP);
    assign cmd_rd   = (state == PUSH) ? RD_PUSH : (state == POP) ? RD_POP : rd_q;
    assign cmd_data = (state == PUSH) ? word : '0;
    assign m_valid  = (state == EMIT);
    assign m_data   = m_data_q;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign err      = err_q;

endmodule

// File: tb/tb_heap_sort_sequencer.sv
// Randomized bench: a behavioural max-heap responder serves the command port,
// and sorted output is compared with a descending sort of each job's inputs.
module tb_heap_sort_sequencer;

    localparam int DW  = 32;
    localparam int HS  = 25;
    localparam int GAP = 7;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [4:0]    count = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          cmd_v;
    logic [4:0]    cmd_rd;
    logic [DW-1:0] cmd_data;
    logic [DW-1:0] rsp_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          busy, done, err;

    heap_sort_sequencer #(.DW(DW), .HEAP_SIZE(HS), .GAP(GAP)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .count    (count),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .cmd_v    (cmd_v),
        .cmd_rd   (cmd_rd),
        .cmd_data (cmd_data),
        .rsp_data (rsp_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0, last_cmd = -1000, cmd_cnt = 0, done_cnt = 0, err_cnt = 0;
    bit hold_low = 1'b0;
    int mi;
    logic [DW-1:0] heap_q[$], push_log[$], out_q[$], job[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sink driver, heap responder and event counters, all sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        m_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        if (m_valid && m_ready) out_q.push_back(m_data);
        if (cmd_v) begin
            check("cmd_spacing", (cyc - last_cmd) >= GAP + 1, 1);
            last_cmd = cyc;
            cmd_cnt++;
            if (cmd_rd == 5'd0) begin
                heap_q.push_back(cmd_data);
                push_log.push_back(cmd_data);
            end else begin
                check("pop_nonempty", heap_q.size() != 0, 1);
                if (heap_q.size() != 0) begin
                    mi = 0;
                    for (int i = 1; i < heap_q.size(); i++)
                        if (heap_q[i] > heap_q[mi]) mi = i;
                    rsp_data = heap_q[mi];
                    heap_q.delete(mi);
                end
            end
        end
        if (done) done_cnt++;
        if (err) err_cnt++;
    end

    task automatic fill_random(input int n);
        job.delete();
        for (int i = 0; i < n; i++) job.push_back($urandom);
    endtask

    task automatic start_job(input int n);
        start = 1'b1;
        count = n[4:0];
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input int from, input int num);
        int t;
        for (int k = from; k < from + num; k++) begin
            s_valid = 1'b1;
            s_data  = job[k];
            t = 0;
            while (!s_ready && t < 400) begin
                @(negedge clk);
                t++;
            end
            if (t >= 400) check("load_timeout", 0, 1);
            @(negedge clk);
            s_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input int d0);
        int t = 0;
        while (done_cnt == d0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("done_pulse", done_cnt, d0 + 1);
        @(negedge clk);
        check("idle_after", busy, 0);
    endtask

    task automatic verify(input int n);
        logic [DW-1:0] expq[$];
        expq = job;
        expq.rsort();
        check("push_count", push_log.size(), n);
        check("out_count", out_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < push_log.size()) check("push_data", push_log[i], job[i]);
            if (i < out_q.size()) check("out_data", out_q[i], expq[i]);
        end
    endtask

    task automatic run_job(input int n, input bit poke);
        int d0 = done_cnt;
        push_log.delete();
        out_q.delete();
        start_job(n);
        if (poke) begin
            feed(0, 1);
            start = 1'b1;
            count = 5'd3;
            @(negedge clk);
            start = 1'b0;
            feed(1, n - 1);
        end else begin
            feed(0, n);
        end
        wait_done(d0);
        verify(n);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_cmd_v"}, cmd_v, 0);
        check({tag, "_cmd_rd"}, cmd_rd, 0);
        check({tag, "_cmd_data"}, cmd_data, 0);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    task automatic bad_start(input int n);
        int e0 = err_cnt;
        int c0 = cmd_cnt;
        start_job(n);
        check("bad_busy", busy, 0);
        repeat (5) @(negedge clk);
        check("bad_err", err_cnt, e0 + 1);
        check("bad_no_cmd", cmd_cnt, c0);
        check("bad_busy_late", busy, 0);
    endtask

    initial begin
        int t, c0, d0;
        logic [DW-1:0] m0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);

        // three-element directed job
        job.delete();
        job.push_back(32'd5);
        job.push_back(32'd9);
        job.push_back(32'd2);
        run_job(3, 1'b0);

        bad_start(0);
        bad_start(26);

        // stalled sink holds the first result
        fill_random(2);
        push_log.delete();
        out_q.delete();
        d0 = done_cnt;
        hold_low = 1'b1;
        start_job(2);
        feed(0, 2);
        t = 0;
        while (!m_valid && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("hold_reach_emit", m_valid, 1);
        m0 = m_data;
        c0 = cmd_cnt;
        repeat (10) begin
            @(negedge clk);
            check("hold_m_valid", m_valid, 1);
            check("hold_m_data", m_data, m0);
        end
        check("hold_no_cmd", cmd_cnt, c0);
        hold_low = 1'b0;
        wait_done(d0);
        verify(2);

        // reset during the second push wait
        fill_random(4);
        d0 = done_cnt;
        start_job(4);
        feed(0, 2);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        reset = 1'b1;
        heap_q.delete();
        c0 = cmd_cnt;
        repeat (30) @(negedge clk);
        check("midrst_no_cmd", cmd_cnt, c0);
        check("midrst_idle", busy, 0);
        check("midrst_no_done", done_cnt, d0);

        fill_random(5);
        run_job(5, 1'b1);

        fill_random(HS);
        run_job(HS, 1'b0);

        repeat (4) begin
            t = $urandom_range(1, HS);
            fill_random(t);
            run_job(t, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
